// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered NCH-channel, WIDTH-bit multiplexer with a manual
// select mode and an automatic round-robin scan mode. The selected channel is
// captured into an output register that is handed off with a valid/ready
// handshake, so a stalled consumer never loses or skips a sample.
//
// Ports:
//   clk_i        single clock, all state updates on the rising edge
//   reset_i      synchronous, active-high reset
//   in_i         flat channel bus, channel k = in_i[k*WIDTH +: WIDTH]
//   select_i     manual-mode channel index
//   load_i       manual mode: capture select_i and request one sample
//   mode_i       0 = manual, 1 = scan
//   out_o        registered sample
//   out_ch_o     channel index of the sample in out_o
//   out_valid_o  out_o/out_ch_o hold a sample
//   out_ready_i  consumer accepts the sample when out_valid_o && out_ready_i
//   err_o        one-cycle pulse on an out-of-range manual select
module mux_scan_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NCH*WIDTH-1:0] in_i,
    input  logic [SELW-1:0]      select_i,
    input  logic                 load_i,
    input  logic                 mode_i,
    output logic [WIDTH-1:0]     out_o,
    output logic [SELW-1:0]      out_ch_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 err_o
);

    localparam int unsigned CNTW = $clog2(DWELL) + 1;
    localparam logic [SELW-1:0] LastSel = SELW'(NCH - 1);
    localparam logic [CNTW-1:0] LastCnt = CNTW'(DWELL - 1);

    logic [SELW-1:0]  sel_q, sel_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] sample;
    logic             free;
    logic             capture;
    logic             legal_sel;

    // Channel mux driven only by the registered index; indices at or above NCH
    // cannot reach sel_q, the zero default just keeps the mux fully defined.
    always_comb begin
        sample = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (sel_q == SELW'(k)) begin
                sample = in_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign free      = !out_valid_q || out_ready_i;
    assign legal_sel = (32'(select_i) < NCH);

    always_comb begin
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        mode_d  = mode_i;
        err_d   = 1'b0;
        capture = 1'b0;

        if (mode_i != mode_q) begin
            // Switching modes restarts the dwell and drops any manual request;
            // the channel index carries over.
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (!mode_q) begin
            cnt_d = '0;
            if (pend_q && free) begin
                capture = 1'b1;
                pend_d  = 1'b0;
            end
            // A load in the capture cycle re-arms pend, so a second sample
            // follows from the new index; the capture still uses the old one.
            if (load_i) begin
                if (legal_sel) begin
                    sel_d  = select_i;
                    pend_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            if (cnt_q == LastCnt) begin
                // Hold at the end of the dwell until the output slot frees up.
                if (free) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    sel_d   = (sel_q == LastSel) ? '0 : sel_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            out_d       = sample;
            out_ch_d    = sel_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sel_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            mode_q      <= 1'b0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            mode_q      <= mode_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_o       = out_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed bench for mux_scan_reg. u_dut4 (NCH=4) covers
// reset, manual select, backpressure, scan timing and stalls; u_dut3 (NCH=3)
// covers the out-of-range select and the wrap at NCH-1. Samples of u_dut4 are
// matched against a queue of expected (data, channel) pairs.
module tb_mux_scan_reg;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ch;
    } exp_t;

    logic        clk;
    logic        rst;

    logic [31:0] in1;
    logic [1:0]  sel1;
    logic        load1, mode1, rdy1;
    logic [7:0]  out1;
    logic [1:0]  och1;
    logic        ov1, err1;

    logic [23:0] in2;
    logic [1:0]  sel2;
    logic        load2, mode2, rdy2;
    logic [7:0]  out2;
    logic [1:0]  och2;
    logic        ov2, err2;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;

    mux_scan_reg #(.WIDTH(8), .NCH(4), .SELW(2), .DWELL(4)) u_dut4 (
        .clk_i       (clk),
        .reset_i     (rst),
        .in_i        (in1),
        .select_i    (sel1),
        .load_i      (load1),
        .mode_i      (mode1),
        .out_o       (out1),
        .out_ch_o    (och1),
        .out_valid_o (ov1),
        .out_ready_i (rdy1),
        .err_o       (err1)
    );

    mux_scan_reg #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(4)) u_dut3 (
        .clk_i       (clk),
        .reset_i     (rst),
        .in_i        (in2),
        .select_i    (sel2),
        .load_i      (load2),
        .mode_i      (mode2),
        .out_o       (out2),
        .out_ch_o    (och2),
        .out_valid_o (ov2),
        .out_ready_i (rdy2),
        .err_o       (err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // A fresh sample is on the outputs when valid rises or when the previous
    // sample was handed off and valid stayed high.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && ov1 && (!prev_valid || prev_hs)) begin
            n_checks++;
            assert (q.size() > 0)
            else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed sample %0h ch %0d, expected none", out1, och1);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_data", 32'(out1), 32'(e.data));
                chk("sb_ch", 32'(och1), 32'(e.ch));
            end
        end
        prev_valid <= ov1;
        prev_hs    <= ov1 && rdy1;
    end

    initial begin
        logic [31:0] pat;
        pat   = 32'hDDCCBBAA;
        rst   = 1'b1;
        in1   = 32'hDDCCBBAA;
        sel1  = '0;
        load1 = 1'b0;
        mode1 = 1'b0;
        rdy1  = 1'b1;
        in2   = 24'hCCBBAA;
        sel2  = '0;
        load2 = 1'b0;
        mode2 = 1'b0;
        rdy2  = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_out", 32'(out1), 0);
        chk("rst_ch", 32'(och1), 0);
        chk("rst_valid", 32'(ov1), 0);
        chk("rst_err", 32'(err1), 0);
        chk("rst_valid3", 32'(ov2), 0);
        mon_en = 1'b1;

        // Manual single load: one cycle of latency after the load edge.
        load1 = 1'b1;
        sel1  = 2'd2;
        q.push_back({8'hCC, 2'd2});
        step();
        load1 = 1'b0;
        chk("man_lat_valid", 32'(ov1), 0);
        step();
        chk("man_out", 32'(out1), 32'hCC);
        chk("man_ch", 32'(och1), 2);
        chk("man_valid", 32'(ov1), 1);
        step();
        chk("man_valid_drop", 32'(ov1), 0);
        in1 = 32'h11223344;
        step(3);
        chk("man_no_load_out", 32'(out1), 32'hCC);
        chk("man_no_load_valid", 32'(ov1), 0);

        // Backpressure with overwritten select: latest select wins.
        in1   = 32'hDDCCBBAA;
        rdy1  = 1'b0;
        load1 = 1'b1;
        sel1  = 2'd0;
        q.push_back({8'hAA, 2'd0});
        step();
        load1 = 1'b0;
        step();
        chk("bp_held_out", 32'(out1), 32'hAA);
        chk("bp_held_valid", 32'(ov1), 1);
        load1 = 1'b1;
        sel1  = 2'd1;
        step();
        sel1 = 2'd3;
        step();
        load1 = 1'b0;
        q.push_back({8'hDD, 2'd3});
        step(3);
        chk("bp_frozen_out", 32'(out1), 32'hAA);
        chk("bp_frozen_ch", 32'(och1), 0);
        chk("bp_frozen_valid", 32'(ov1), 1);
        rdy1 = 1'b1;
        step();
        chk("bp_next_out", 32'(out1), 32'hDD);
        chk("bp_next_ch", 32'(och1), 3);
        chk("bp_next_valid", 32'(ov1), 1);
        step();
        chk("bp_one_extra", 32'(ov1), 0);
        step(4);
        chk("bp_no_more", 32'(ov1), 0);
        chk("bp_queue_empty", 32'(q.size()), 0);

        // Scan keeps sel_q=3 from manual mode; reset while a sample is up.
        mode1 = 1'b1;
        q.push_back({8'hDD, 2'd3});
        step(5);
        chk("scan_pre_out", 32'(out1), 32'hDD);
        chk("scan_pre_valid", 32'(ov1), 1);
        chk("scan_err", 32'(err1), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_out", 32'(out1), 0);
        chk("rst2_ch", 32'(och1), 0);
        chk("rst2_valid", 32'(ov1), 0);
        chk("rst2_err", 32'(err1), 0);
        chk("rst2_queue", 32'(q.size()), 0);
        q.delete();

        // Scan from channel 0: first sample DWELL cycles after the mode switch edge.
        for (int i = 0; i < 5; i++) begin
            q.push_back({pat[(i % 4) * 8 +: 8], 2'(i % 4)});
        end
        step(4);
        chk("scan_first_wait", 32'(ov1), 0);
        step();
        chk("scan_out0", 32'(out1), 32'(pat[7:0]));
        chk("scan_ch0", 32'(och1), 0);
        for (int i = 1; i < 5; i++) begin
            step(3);
            chk("scan_gap_valid", 32'(ov1), 0);
            step();
            chk("scan_out", 32'(out1), 32'(pat[(i % 4) * 8 +: 8]));
            chk("scan_ch", 32'(och1), 32'(i % 4));
            chk("scan_valid", 32'(ov1), 1);
        end

        // Scan stall on BB: nothing skipped, CC follows right after release.
        q.push_back({8'hBB, 2'd1});
        q.push_back({8'hCC, 2'd2});
        q.push_back({8'hDD, 2'd3});
        step(4);
        chk("stall_bb_out", 32'(out1), 32'hBB);
        rdy1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_out", 32'(out1), 32'hBB);
            chk("stall_ch", 32'(och1), 1);
        end
        rdy1 = 1'b1;
        step();
        chk("stall_cc_out", 32'(out1), 32'hCC);
        chk("stall_cc_ch", 32'(och1), 2);
        step(4);
        chk("stall_dd_out", 32'(out1), 32'hDD);
        chk("stall_dd_ch", 32'(och1), 3);

        // Mode toggle mid-dwell restarts the dwell count.
        step(2);
        mode1 = 1'b0;
        step();
        mode1 = 1'b1;
        q.push_back({8'hAA, 2'd0});
        step(4);
        chk("toggle_wait", 32'(ov1), 0);
        step();
        chk("toggle_out", 32'(out1), 32'hAA);
        chk("toggle_ch", 32'(och1), 0);
        chk("toggle_valid", 32'(ov1), 1);
        step();
        mon_en = 1'b0;
        chk("sb_drained", 32'(q.size()), 0);

        // NCH=3 instance: legal load, then an out-of-range select.
        load2 = 1'b1;
        sel2  = 2'd1;
        step();
        load2 = 1'b0;
        step();
        chk("n3_out", 32'(out2), 32'hBB);
        chk("n3_ch", 32'(och2), 1);
        chk("n3_err_legal", 32'(err2), 0);
        step();
        chk("n3_valid_drop", 32'(ov2), 0);
        load2 = 1'b1;
        sel2  = 2'd3;
        step();
        load2 = 1'b0;
        chk("ill_err", 32'(err2), 1);
        chk("ill_valid", 32'(ov2), 0);
        step();
        chk("ill_err_pulse", 32'(err2), 0);
        step(3);
        chk("ill_no_sample", 32'(ov2), 0);

        // Scan from the unchanged sel_q=1 and wrap from channel 2 to 0.
        mode2 = 1'b1;
        step(5);
        chk("n3_scan_out1", 32'(out2), 32'hBB);
        chk("n3_scan_ch1", 32'(och2), 1);
        step(4);
        chk("n3_scan_out2", 32'(out2), 32'hCC);
        chk("n3_scan_ch2", 32'(och2), 2);
        step(4);
        chk("n3_wrap_out", 32'(out2), 32'hAA);
        chk("n3_wrap_ch", 32'(och2), 0);
        chk("n3_wrap_valid", 32'(ov2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Registered, parametrised N-channel, W-bit multiplexer with two modes: manual channel select and automatic round-robin scan.
- Output is a registered sample with a valid/ready handshake, so the downstream consumer can stall without losing data.
- Sits between parallel sensor/data inputs and a single serial consumer; generalises the 4:1 single-bit selector.

Parameters:
- WIDTH, 8, bit width of each channel
- NCH, 4, number of channels (2..2**SELW)
- SELW, 2, width of channel index
- DWELL, 4, scan-mode cycles per channel (>=1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in  input  NCH*WIDTH  flat channel bus; channel k = in[k*WIDTH +: WIDTH]
- select  input  SELW  manual-mode channel index
- load  input  1  manual mode: capture select and request one sample
- mode  input  1  0 = manual, 1 = scan
- out  output  WIDTH  registered sample
- out_ch  output  SELW  channel index of the sample in out
- out_valid  output  1  out/out_ch hold a sample
- out_ready  input  1  consumer accepts the sample when out_valid && out_ready
- err  output  1  one-cycle pulse on an illegal manual select

Behaviour:
- Reset (synchronous, active-high, at any time, including mid-stall): sel_q=0, cnt=0, pend=0, mode_q=0, out=0, out_ch=0, out_valid=0, err=0.
- free = !out_valid || out_ready. Capture means:
  - out <= in[sel_q]
  - out_ch <= sel_q
  - out_valid <= 1
- If out_valid && out_ready and there is no capture that cycle, out_valid <= 0.
- While out_valid && !out_ready, out and out_ch are frozen regardless of changes on in.
- Mode change (mode != mode_q): cnt <= 0 and pend <= 0. sel_q is kept. mode_q <= mode. No capture or load is processed that cycle.
- Manual mode (mode=0):
  - load with select < NCH: sel_q <= select, pend <= 1.
  - load with select >= NCH: err <= 1 for one cycle; sel_q and pend are unchanged.
  - When pend && free, capture and clear pend. Latency: load sampled at edge N gives out_valid high after edge N+1 (if free).
  - load while pend is already set (stalled): sel_q is overwritten and the latest select wins; only one sample is produced.
  - load in the same cycle as a capture: the capture uses the old sel_q; the new sel_q is stored and pend stays 1, so a second sample follows.
  - cnt is held at 0.
- Scan mode (mode=1):
  - load and select are ignored; err stays 0.
  - cnt increments each cycle until it reaches DWELL-1.
  - At cnt==DWELL-1 and free: capture in[sel_q], then sel_q <= (sel_q==NCH-1) ? 0 : sel_q+1 and cnt <= 0.
  - At cnt==DWELL-1 and not free: cnt and sel_q hold. No channel is skipped and no sample is dropped.
  - With DWELL=1 and out_ready held at 1, one sample is produced per cycle.
- Arithmetic:
  - sel_q wraps explicitly at NCH-1, not at 2**SELW.
  - cnt width is clog2(DWELL)+1; it never exceeds DWELL-1.
- All outputs are registered; there is no combinational path from in, select or out_ready to any output.

Test Plan:
- Reset: NCH=4, WIDTH=8, in=32'hDDCCBBAA, scan running with out_valid=1; assert reset for 1 cycle → next cycle out=0, out_ch=0, out_valid=0, err=0; scan restarts at channel 0 with cnt=0.
- Manual: mode=0, out_ready=1, load=1 with select=2 for 1 cycle → one cycle after the load edge, out=8'hCC, out_ch=2, out_valid=1; next cycle out_valid=0. Then change in to 32'h11223344 with no load → out does not change.
- Manual backpressure plus overwrite: out_ready=0 with a sample held; load select=1, then select=3 → out holds; after out_ready=1, the next sample is out=8'hDD, out_ch=3; exactly one extra sample is produced.
- Illegal select: instance NCH=3; load select=3 → err=1 for exactly 1 cycle; sel_q unchanged; no new out_valid.
- Scan: mode=1, DWELL=4, out_ready=1 → out sequence AA, BB, CC, DD, AA, spaced 4 cycles apart, with out_ch 0, 1, 2, 3, 0.
- Scan stall: drop out_ready for 10 cycles while out=BB → out stays BB and out_ch stays 1. After out_ready returns, CC is emitted on the next cycle (cnt was held at DWELL-1), followed by DD 4 cycles later. Mode toggle mid-dwell → cnt resets and the first sample arrives DWELL cycles after the switch.
